// File: rtl/tape_pkg.sv
// Shared types and default constants for the cassette tape recorder.
package tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_DATA = 2'd2,
    ST_STOP = 2'd3
  } tape_state_e;

  localparam int SHORT_MAX_DEF  = 16;
  localparam int TIMEOUT_DEF    = 255;
  localparam int MIN_PERIOD_DEF = 3;

  // Increment an 8-bit tick count, sticking at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Clamp an integer tick constant into the 8-bit period range.
  function automatic logic [7:0] to_ticks(input int v);
    if (v > 255) begin
      return 8'hFF;
    end else if (v < 0) begin
      return 8'h00;
    end else begin
      return 8'(v);
    end
  endfunction

endpackage

// File: rtl/tape_period.sv
// Input synchroniser, rising-edge detector and period counter.
// Optional macro TAPE_REC_GLITCH_EN: edges closer than MIN_PERIOD ticks
// to the last accepted edge are ignored and do not restart the count.
module tape_period
  import tape_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       din,
  input  logic       clr,
  output logic [7:0] period,
  output logic       valid,
  output logic       stale
);

  localparam logic [7:0] TIMEOUT_T = to_ticks(TIMEOUT);
  localparam logic [7:0] MIN_T     = to_ticks(MIN_PERIOD);
`ifdef TAPE_REC_GLITCH_EN
  localparam logic GLITCH_EN = 1'b1;
`else
  localparam logic GLITCH_EN = 1'b0;
`endif

  logic       sync1_r, sync2_r, samp_r;
  logic [7:0] cnt_r, cnt_inc_s, period_r;
  logic       valid_r, stale_r;
  logic       edge_s, accept_s;

  // Edge qualification: a rising edge seen on a tick, filtered by the glitch floor.
  always_comb begin
    cnt_inc_s = sat_inc8(cnt_r);
    edge_s    = ce & sync2_r & ~samp_r;
    accept_s  = edge_s & (~GLITCH_EN | (cnt_inc_s >= MIN_T));
  end

  // Two-flop synchroniser plus the tick-rate sample used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      samp_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (ce) begin
        samp_r <= sync2_r;
      end
    end
  end

  // Saturating tick counter, restarted by every accepted edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 8'd0;
    end else if (clr || accept_s) begin
      cnt_r <= 8'd0;
    end else if (ce) begin
      cnt_r <= cnt_inc_s;
    end
  end

  // Registered period/valid strobe and the no-edge timeout strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_r <= 8'd0;
      valid_r  <= 1'b0;
      stale_r  <= 1'b0;
    end else begin
      valid_r <= accept_s & ~clr;
      stale_r <= ce & ~accept_s & ~clr & (cnt_inc_s >= TIMEOUT_T);
      if (accept_s) begin
        period_r <= cnt_inc_s;
      end
    end
  end

  assign period = period_r;
  assign valid  = valid_r;
  assign stale  = stale_r;

endmodule

// File: rtl/tape_rec.sv
// Cassette tape recorder: decodes pulse-width bits into framed bytes and
// emits them as a write stream. Optional macro TAPE_REC_GLITCH_EN enables
// the short-period glitch filter in tape_period.
module tape_rec
  import tape_pkg::*;
#(
  parameter int SHORT_MAX  = SHORT_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_rec,
  input  logic        arm,
  input  logic        in,
  output logic        wr,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic [15:0] length,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] SHORT_T = to_ticks(SHORT_MAX);

  tape_state_e state_r, state_nxt_s;
  logic [7:0]  period_s, shift_r, data_r;
  logic [15:0] addr_r, len_r;
  logic [2:0]  bcnt_r;
  logic        valid_s, stale_s, clr_s;
  logic        arm_r, first_r, stop1_r, full_r;
  logic        wr_r, done_r, busy_r, err_r;
  logic        bit_s, bit_ev_s, arm_rise_s, len_nz_s;
  logic        wr_ev_s, err_ev_s, done_ev_s, clr_ev_s, start_ev_s, shift_ev_s, stop1_ev_s;

  assign clr_s = (state_r == ST_IDLE);

  tape_period #(.TIMEOUT(TIMEOUT), .MIN_PERIOD(MIN_PERIOD)) u_period (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce_rec),
    .din     (in),
    .clr     (clr_s),
    .period  (period_s),
    .valid   (valid_s),
    .stale   (stale_s)
  );

  // Bit decode and next-state/action selection; dropping arm overrides everything.
  always_comb begin
    bit_s       = (period_s <= SHORT_T);
    bit_ev_s    = valid_s & ~first_r;
    arm_rise_s  = arm & ~arm_r;
    len_nz_s    = (len_r != 16'h0000);
    state_nxt_s = state_r;
    wr_ev_s     = 1'b0;
    err_ev_s    = 1'b0;
    done_ev_s   = 1'b0;
    clr_ev_s    = 1'b0;
    start_ev_s  = 1'b0;
    shift_ev_s  = 1'b0;
    stop1_ev_s  = 1'b0;
    if (!arm) begin
      state_nxt_s = ST_IDLE;
      done_ev_s   = (state_r != ST_IDLE) && len_nz_s;
    end else if ((state_r != ST_IDLE) && stale_s) begin
      state_nxt_s = ST_IDLE;
      done_ev_s   = len_nz_s;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm_rise_s) begin
            state_nxt_s = ST_HUNT;
            clr_ev_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HUNT: begin
          if (bit_ev_s && !bit_s) begin
            state_nxt_s = ST_DATA;
            start_ev_s  = 1'b1;
          end else begin
            state_nxt_s = ST_HUNT;
          end
        end
        ST_DATA: begin
          if (bit_ev_s) begin
            shift_ev_s  = 1'b1;
            state_nxt_s = (bcnt_r == 3'd7) ? ST_STOP : ST_DATA;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_STOP: begin
          if (bit_ev_s && bit_s && stop1_r) begin
            wr_ev_s     = 1'b1;
            state_nxt_s = ST_HUNT;
          end else if (bit_ev_s && bit_s) begin
            stop1_ev_s  = 1'b1;
          end else if (bit_ev_s) begin
            err_ev_s    = 1'b1;
            start_ev_s  = 1'b1;
            state_nxt_s = ST_DATA;
          end else begin
            state_nxt_s = ST_STOP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arm history and the "first edge after arm carries no bit" flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_r   <= 1'b0;
      first_r <= 1'b0;
    end else begin
      arm_r <= arm;
      if (clr_ev_s) begin
        first_r <= 1'b1;
      end else if (valid_s) begin
        first_r <= 1'b0;
      end
    end
  end

  // Byte assembly: LSB-first shift register, bit count and first-stop flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_r <= 8'd0;
      bcnt_r  <= 3'd0;
      stop1_r <= 1'b0;
    end else if (start_ev_s) begin
      shift_r <= 8'd0;
      bcnt_r  <= 3'd0;
      stop1_r <= 1'b0;
    end else if (shift_ev_s) begin
      shift_r <= {bit_s, shift_r[7:1]};
      bcnt_r  <= bcnt_r + 3'd1;
    end else if (stop1_ev_s) begin
      stop1_r <= 1'b1;
    end
  end

  // Registered strobes and status; data only changes on a real write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_r   <= 1'b0;
      data_r <= 8'd0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      wr_r   <= wr_ev_s & ~full_r;
      done_r <= done_ev_s;
      busy_r <= (state_nxt_s == ST_DATA) || (state_nxt_s == ST_STOP);
      if (wr_ev_s && !full_r) begin
        data_r <= shift_r;
      end
      if (clr_ev_s) begin
        err_r <= 1'b0;
      end else if (err_ev_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Address/length advance the cycle after each strobe so addr names the byte being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= 16'h0000;
      len_r  <= 16'h0000;
      full_r <= 1'b0;
    end else if (clr_ev_s) begin
      addr_r <= 16'h0000;
      len_r  <= 16'h0000;
      full_r <= 1'b0;
    end else if (wr_r) begin
      if (addr_r == 16'hFFFF) begin
        full_r <= 1'b1;
        len_r  <= 16'hFFFF;
      end else begin
        addr_r <= addr_r + 16'd1;
        len_r  <= len_r + 16'd1;
      end
    end
  end

  assign wr     = wr_r;
  assign addr   = addr_r;
  assign data   = data_r;
  assign length = len_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;

endmodule

// File: doc/tape_rec.md
TAPE_REC -- requirements
Module: tape_rec

Interface
REQ-001 SHALL have parameter SHORT_MAX, default 16: longest period in ce_rec ticks decoded as bit 1; longer periods decode as bit 0.
REQ-002 SHALL have parameter TIMEOUT, default 255: idle ticks without an edge that end a recording.
REQ-003 SHALL have parameter MIN_PERIOD, default 3: glitch floor, used only under REQ-027.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ce_rec, input, 1 bit: sample/tick enable, one clk wide.
REQ-007 SHALL have port arm, input, 1 bit: recording enabled while high.
REQ-008 SHALL have port in, input, 1 bit: cassette output level from the PLA, asynchronous to clk.
REQ-009 SHALL have outputs wr (1 bit, byte write strobe), addr (16 bits, write address) and data (8 bits, write byte).
REQ-010 SHALL have outputs length (16 bits, bytes captured), busy (1 bit, frame in progress), done (1 bit, end pulse) and err (1 bit, sticky framing error).

Function
REQ-011 SHALL synchronise in through 2 flops, then detect rising edges on samples taken when ce_rec=1.
REQ-012 SHALL count ticks between rising edges in an 8-bit counter that saturates at 255; each edge yields one period and clears the counter.
REQ-013 SHALL decode a period <= SHORT_MAX as bit 1 and a period > SHORT_MAX as bit 0; the first edge after arm rises yields no bit.
REQ-014 SHALL implement states IDLE, HUNT, DATA, STOP.
REQ-015 SHALL move IDLE->HUNT on arm=1; bit 1s in HUNT are leader and are ignored.
REQ-016 SHALL move HUNT->DATA on a bit 0 (start bit), clear the shift register, and set bit count to 0.
REQ-017 SHALL in DATA shift bits in LSB first and go to STOP after the 8th bit.
REQ-018 SHALL in STOP expect two bit 1s; after the second, pulse wr for 1 clk with data=byte, then increment addr and length, then return to HUNT.
REQ-019 SHALL treat a bit 0 in STOP as a framing error: set err, discard the byte, and treat that 0 as a new start bit (enter DATA).
REQ-020 SHALL, when TIMEOUT ticks pass without an edge in HUNT/DATA/STOP, discard any partial byte, pulse done for 1 clk if length>0, and enter IDLE.
REQ-021 SHALL, on arm=0 in any state, enter IDLE next clk, discard the partial byte, and pulse done if length>0; arm=0 takes priority over a same-cycle edge or wr.
REQ-022 SHALL, when a write occurs at addr=0xFFFF, suppress further writes and hold addr at 0xFFFF and length at 0xFFFF until re-armed.
REQ-023 SHALL, on arm 0->1, clear addr, length and err.
REQ-024 SHALL drive busy=1 in DATA and STOP only.
REQ-025 SHALL drive data stable from the wr cycle until the next wr.

Reset
REQ-026 SHALL, while reset_n=0, force state=IDLE and wr=0, addr=0, data=0, length=0, busy=0, done=0, err=0, synchronisers=0, counters=0, with no reliance on clk.

Configuration
REQ-027 SHALL, when TAPE_REC_GLITCH_EN is defined, ignore edges whose period is < MIN_PERIOD: the period counter is not cleared and no bit is produced; without the macro, every edge is a period and MIN_PERIOD is unused.

Structure
REQ-028 SHALL take the state enum and the SHORT_MAX/TIMEOUT/MIN_PERIOD default constants from shared package tape_pkg.
REQ-029 SHALL place synchroniser, edge detect and period counter in sub-module tape_period, which outputs a period value and a valid strobe.

Verification
REQ-030 SHALL cover: arm, 20 periods of 8, start 20, byte 0xA5 LSB-first (periods 8/20), stops 8,8 -> one wr, data=0xA5, addr=0 at the strobe, then length=1.
REQ-031 SHALL cover: a 0xFF byte, then a 20-tick stop -> err=1, no wr, next 8 bits captured as a new byte.
REQ-032 SHALL cover: 3 good bytes, then an idle of 255 ticks -> one done pulse, length=3, state IDLE.
REQ-033 SHALL cover: arm dropped after 4 data bits -> no wr, busy=0 next clk, done=0 since length=0.
REQ-034 SHALL cover: addr preset path to 0xFFFF via 65536 writes (or forced) -> last wr at 0xFFFF, no further wr.
REQ-035 SHALL cover: with TAPE_REC_GLITCH_EN, 1-tick spikes inside 20-tick periods -> decoded bytes identical to the clean run; without the macro -> err=1.
